dtree_channel_scheduler: RTL and testbench
==========================================

// Module: dtree_channel_scheduler
// PURPOSE
//  Shares a single dtree classifier core between CHANNEL_COUNT spike channels.
//  - Each channel hands over a complete feature vector, which is buffered 1-deep per channel.
//  - Channels are granted round-robin.
//  - The granted vector is serialised to the core one feature per cycle, gated by core_ready.
//  - The core's channel select is driven while the vector is in flight.
//  - The core's level/path result is captured and returned tagged with the originating channel.
// PARAMETERS
//  FEATURES       3   features per vector; also sets level/path width LP_W=$clog2(FEATURES)
//  IN_WIDTH      10   signed feature width
//  CHANNEL_COUNT  4   channels sharing the core; must be >=2; CH_W=$clog2(CHANNEL_COUNT)
// PORTS
//  clk            in   1                      single clock, rising edge
//  reset          in   1                      synchronous, active-high
//  ch_valid       in   CHANNEL_COUNT          per-channel vector offer
//  ch_ready       out  CHANNEL_COUNT          per-channel holding register empty
//  ch_vector      in   CHANNEL_COUNT*FEATURES*IN_WIDTH  channel i = slice i; feature 0 in LSBs of slice
//  core_ready     in   1                      dtree ready (node memory full, core idle)
//  core_in_valid  out  1                      feature valid to core
//  core_sample    out  IN_WIDTH               feature to core
//  core_ch_index  out  CH_W                   node-set select for the core
//  core_out_valid in   1                      core result strobe
//  core_level     in   LP_W                   core leaf level
//  core_path      in   LP_W                   core leaf path
//  res_valid      out  1                      tagged result strobe, 1 cycle
//  res_channel    out  CH_W                   originating channel
//  res_level      out  LP_W                   registered core_level
//  res_path       out  LP_W                   registered core_path
// BEHAVIOUR
//  - Reset values: ch_ready = all 1, core_in_valid=0, core_sample=0, core_ch_index=0, res_*=0.
//  - Reset state: FSM IDLE, RR pointer=0, all holding registers empty.
//  - Reset mid-operation discards the in-flight vector and all buffered vectors.
//  - Capture: ch_valid[i] & ch_ready[i] writes slice i into hold[i]; full[i]<=1; ch_ready[i]=~full[i].
//  FSM:
//  - IDLE: if any full[], grant the first full channel at or after the RR pointer.
//    - Copy the vector to the issue register; full[g]<=0; core_ch_index<=g; feat_cnt<=0.
//    - RR pointer <= g+1 (mod CHANNEL_COUNT); go to ISSUE.
//  - ISSUE: core_in_valid = core_ready; core_sample = feature[feat_cnt].
//    - On core_ready, feat_cnt++. After feature FEATURES-1 is accepted, go to WAIT.
//    - core_ready low pauses issue; sample and feat_cnt hold.
//  - WAIT: on core_out_valid, register level/path and res_channel=core_ch_index.
//    - res_valid=1 on the next cycle; go to IDLE in that same cycle.
//  - core_ch_index holds stable from grant until the WAIT->IDLE transition.
//  - Latency: the first feature issues 1 cycle after grant (core_ready=1).
//  - res_valid follows core_out_valid by exactly 1 cycle.
//  - Best-case back-to-back grant: IDLE is visited for 1 cycle between vectors.
//  - core_out_valid outside WAIT is ignored. ch_valid while ~ch_ready is ignored (vector lost).
//  - A granted channel may recapture from the cycle after grant: full clears at grant, ch_ready rises next cycle.
//  - Capture and grant of different channels in the same cycle are independent.
//  - Features are passed unmodified; no arithmetic on the datapath. RR pointer wraps CHANNEL_COUNT-1 -> 0.
// CONFIGURATION
//  DTREE_SCHED_DROP_CNT_EN defined:
//  - Extra output drop_count [15:0], reset 0.
//  - Increments once per channel per cycle with ch_valid[i] & ~ch_ready[i].
//  - Multiple drops in one cycle add their popcount.
//  - Saturates at 16'hFFFF.
//  Undefined: no drop_count port and no counter logic; drops are silent.
// TESTING
//  - Single vector, ch1, vector {30,-5,7}, core_ready=1:
//    core_sample 7,-5,30 on 3 consecutive cycles with core_ch_index=1;
//    core_out_valid with level=1,path=2 -> next cycle res_valid, res_channel=1, level 1, path 2.
//  - All 4 channels offer in the same cycle, pointer=0 -> grants 0,1,2,3 in order.
//    ch0 re-offers after its grant -> served after ch3.
//  - core_ready deasserted after feature 0 for 5 cycles -> feature 1 held on core_sample.
//    core_in_valid low for those 5 cycles; exactly 3 accepted features total.
//  - ch2 offers while full[2]=1 -> buffered vector unchanged.
//    With DTREE_SCHED_DROP_CNT_EN: drop_count 0->1; 70000 drops -> saturates at 65535.
//  - Reset asserted in WAIT with hold[3] full -> next cycle all ch_ready=1, core_in_valid=0.
//    A later core_out_valid produces no res_valid.
//  - Spurious core_out_valid in IDLE -> no res_valid; FSM stays IDLE.

Source files
------------

// File: rtl/dtree_channel_scheduler.sv
// dtree_channel_scheduler
// Shares one dtree classifier core between CHANNEL_COUNT spike channels. Each channel hands
// over a complete feature vector into a 1-deep holding register. Full channels are granted
// round-robin. The granted vector is streamed to the core one feature per accepted cycle.
// The core's level/path result is returned tagged with the originating channel.
// Optional feature: define DTREE_SCHED_DROP_CNT_EN to add a saturating drop_count output.
// drop_count counts vectors offered to channels whose holding register was still full.
module dtree_channel_scheduler #(
    parameter int unsigned FEATURES      = 3,
    parameter int unsigned IN_WIDTH      = 10,
    parameter int unsigned CHANNEL_COUNT = 4,
    localparam int unsigned LP_W         = $clog2(FEATURES),
    localparam int unsigned CH_W         = $clog2(CHANNEL_COUNT)
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [CHANNEL_COUNT-1:0]                   ch_valid,
    output logic [CHANNEL_COUNT-1:0]                   ch_ready,
    input  logic [CHANNEL_COUNT*FEATURES*IN_WIDTH-1:0] ch_vector,
    input  logic                                       core_ready,
    output logic                                       core_in_valid,
    output logic [IN_WIDTH-1:0]                        core_sample,
    output logic [CH_W-1:0]                            core_ch_index,
    input  logic                                       core_out_valid,
    input  logic [LP_W-1:0]                            core_level,
    input  logic [LP_W-1:0]                            core_path,
    output logic                                       res_valid,
    output logic [CH_W-1:0]                            res_channel,
    output logic [LP_W-1:0]                            res_level,
    output logic [LP_W-1:0]                            res_path
`ifdef DTREE_SCHED_DROP_CNT_EN
    ,
    output logic [15:0]                                drop_count
`endif
);

    // Feature counter width; kept at least 1 bit so a single-feature build still elaborates.
    localparam int unsigned CNT_W = (FEATURES > 1) ? $clog2(FEATURES) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [CHANNEL_COUNT-1:0] full_q, full_d;
    logic [CHANNEL_COUNT-1:0] capture;
    logic [IN_WIDTH-1:0]      hold_q [CHANNEL_COUNT][FEATURES];
    logic [IN_WIDTH-1:0]      issue_q [FEATURES];
    logic [CNT_W-1:0]         feat_cnt_q, feat_cnt_d;
    logic [CH_W-1:0]          ptr_q, ptr_d;
    logic [CH_W-1:0]          ch_idx_q, ch_idx_d;

    logic                     grant_found;
    logic [CH_W-1:0]          grant_idx;
    int unsigned              cand;
    logic                     do_grant;
    logic                     last_feat;
    logic                     result_take;

    logic                     res_valid_q;
    logic [CH_W-1:0]          res_channel_q;
    logic [LP_W-1:0]          res_level_q;
    logic [LP_W-1:0]          res_path_q;

    // Round-robin search: first full channel at or after the pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned k = 0; k < CHANNEL_COUNT; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= CHANNEL_COUNT) begin
                cand = cand - CHANNEL_COUNT;
            end
            if (!grant_found && full_q[CH_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(cand);
            end
        end
    end

    assign do_grant    = (state_q == StIdle) && grant_found;
    assign last_feat   = (feat_cnt_q == CNT_W'(FEATURES - 1));
    assign result_take = (state_q == StWait) && core_out_valid;

    // Next-state for the grant/issue/wait sequence, pointer and channel select.
    always_comb begin
        state_d    = state_q;
        feat_cnt_d = feat_cnt_q;
        ptr_d      = ptr_q;
        ch_idx_d   = ch_idx_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    state_d    = StIssue;
                    feat_cnt_d = '0;
                    ch_idx_d   = grant_idx;
                    ptr_d      = (grant_idx == CH_W'(CHANNEL_COUNT - 1)) ?
                                 '0 : grant_idx + CH_W'(1);
                end
            end
            StIssue: begin
                // A low core_ready simply holds the current feature on the bus.
                if (core_ready) begin
                    if (last_feat) begin
                        state_d = StWait;
                    end else begin
                        feat_cnt_d = feat_cnt_q + CNT_W'(1);
                    end
                end
            end
            StWait: begin
                if (core_out_valid) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Holding-register occupancy: set on capture, cleared on grant.
    // A granted channel is full by definition, so it cannot capture in its grant cycle.
    always_comb begin
        capture = ch_valid & ~full_q;
        full_d  = full_q | capture;
        if (do_grant) begin
            full_d[grant_idx] = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            full_q     <= '0;
            feat_cnt_q <= '0;
            ptr_q      <= '0;
            ch_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            feat_cnt_q <= feat_cnt_d;
            ptr_q      <= ptr_d;
            ch_idx_q   <= ch_idx_d;
        end
    end

    // Per-channel vector capture; contents are only meaningful while full_q is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(CHANNEL_COUNT); i++) begin
            if (capture[i]) begin
                for (int f = 0; f < int'(FEATURES); f++) begin
                    hold_q[i][f] <= ch_vector[(i*int'(FEATURES) + f)*int'(IN_WIDTH) +: IN_WIDTH];
                end
            end
        end
    end

    // Issue register: snapshot of the granted vector, freeing the channel for a new capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int f = 0; f < int'(FEATURES); f++) begin
                issue_q[f] <= '0;
            end
        end else if (do_grant) begin
            for (int f = 0; f < int'(FEATURES); f++) begin
                issue_q[f] <= hold_q[grant_idx][f];
            end
        end
    end

    // Result capture: one-cycle strobe tagged with the channel in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_q   <= 1'b0;
            res_channel_q <= '0;
            res_level_q   <= '0;
            res_path_q    <= '0;
        end else begin
            res_valid_q <= result_take;
            if (result_take) begin
                res_channel_q <= ch_idx_q;
                res_level_q   <= core_level;
                res_path_q    <= core_path;
            end
        end
    end

    assign ch_ready      = ~full_q;
    assign core_in_valid = (state_q == StIssue) && core_ready;
    assign core_sample   = (state_q == StIssue) ? issue_q[feat_cnt_q] : '0;
    assign core_ch_index = ch_idx_q;
    assign res_valid     = res_valid_q;
    assign res_channel   = res_channel_q;
    assign res_level     = res_level_q;
    assign res_path      = res_path_q;

`ifdef DTREE_SCHED_DROP_CNT_EN
    logic [CHANNEL_COUNT-1:0] drops;
    logic [CH_W:0]            drop_inc;
    logic [16:0]              drop_sum;
    logic [15:0]              drop_cnt_q, drop_cnt_d;

    // Popcount of this cycle's lost offers, added with saturation at all-ones.
    always_comb begin
        drops    = ch_valid & full_q;
        drop_inc = '0;
        for (int i = 0; i < int'(CHANNEL_COUNT); i++) begin
            drop_inc = drop_inc + (CH_W+1)'(drops[i]);
        end
        drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_inc);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dtree_channel_scheduler.sv
// Bench for dtree_channel_scheduler: randomized and directed stimulus, a transaction-level
// reference model (per-channel buffers, round-robin pick, one vector in flight) that queues
// expected features and results, and a negedge monitor that pops and compares.
module tb_dtree_channel_scheduler;
    localparam int FEATURES      = 3;
    localparam int IN_WIDTH      = 10;
    localparam int CHANNEL_COUNT = 4;
    localparam int LP_W          = 2;
    localparam int CH_W          = 2;

    logic                                       clk = 1'b0;
    logic                                       reset;
    logic [CHANNEL_COUNT-1:0]                   ch_valid;
    logic [CHANNEL_COUNT-1:0]                   ch_ready;
    logic [CHANNEL_COUNT*FEATURES*IN_WIDTH-1:0] ch_vector;
    logic                                       core_ready;
    logic                                       core_in_valid;
    logic [IN_WIDTH-1:0]                        core_sample;
    logic [CH_W-1:0]                            core_ch_index;
    logic                                       core_out_valid;
    logic [LP_W-1:0]                            core_level;
    logic [LP_W-1:0]                            core_path;
    logic                                       res_valid;
    logic [CH_W-1:0]                            res_channel;
    logic [LP_W-1:0]                            res_level;
    logic [LP_W-1:0]                            res_path;
`ifdef DTREE_SCHED_DROP_CNT_EN
    logic [15:0]                                drop_count;
`endif

    always #5 clk = ~clk;

    dtree_channel_scheduler #(
        .FEATURES      (FEATURES),
        .IN_WIDTH      (IN_WIDTH),
        .CHANNEL_COUNT (CHANNEL_COUNT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ch_valid       (ch_valid),
        .ch_ready       (ch_ready),
        .ch_vector      (ch_vector),
        .core_ready     (core_ready),
        .core_in_valid  (core_in_valid),
        .core_sample    (core_sample),
        .core_ch_index  (core_ch_index),
        .core_out_valid (core_out_valid),
        .core_level     (core_level),
        .core_path      (core_path),
        .res_valid      (res_valid),
        .res_channel    (res_channel),
        .res_level      (res_level),
        .res_path       (res_path)
`ifdef DTREE_SCHED_DROP_CNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    typedef struct { int ch; int val; } feat_t;
    typedef struct { int ch; int level; int path; } res_t;

    feat_t exp_feat[$];
    res_t  exp_res[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model state
    bit                  m_full [CHANNEL_COUNT];
    bit                  m_snap [CHANNEL_COUNT];
    logic [IN_WIDTH-1:0] m_vec  [CHANNEL_COUNT][FEATURES];
    int                  m_ptr       = 0;
    int                  m_in_flight = -1;
    int                  m_to_send   = 0;
    longint              m_drops     = 0;
    int                  mc;
    bit                  m_found;

    // Core-side behaviour controls
    bit auto_core   = 1'b1;
    bit rand_ready  = 1'b0;
    bit spurious_en = 1'b0;
    int stall_left  = 0;
    int pulse_cnt   = 0;
    int pulse_done  = 0;
    int pulse_lvl   = 0;
    int pulse_pth   = 0;
    int resp_wait   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model, evaluated on the inputs present at each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNEL_COUNT; i++) m_full[i] = 1'b0;
            m_ptr       = 0;
            m_in_flight = -1;
            m_to_send   = 0;
            m_drops     = 0;
            exp_feat.delete();
            exp_res.delete();
        end else begin
            m_snap = m_full;
            if (m_in_flight < 0) begin
                m_found = 1'b0;
                for (int k = 0; k < CHANNEL_COUNT; k++) begin
                    mc = (m_ptr + k) % CHANNEL_COUNT;
                    if (!m_found && m_snap[mc]) begin
                        m_found     = 1'b1;
                        m_in_flight = mc;
                        m_to_send   = FEATURES;
                        for (int f = 0; f < FEATURES; f++)
                            exp_feat.push_back(feat_t'{mc, int'(m_vec[mc][f])});
                        m_full[mc] = 1'b0;
                        m_ptr      = (mc + 1) % CHANNEL_COUNT;
                    end
                end
            end else if (m_to_send > 0) begin
                if (core_ready) m_to_send--;
            end else if (core_out_valid) begin
                exp_res.push_back(res_t'{m_in_flight, int'(core_level), int'(core_path)});
                m_in_flight = -1;
            end
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                if (ch_valid[i]) begin
                    if (!m_snap[i]) begin
                        m_full[i] = 1'b1;
                        for (int f = 0; f < FEATURES; f++)
                            m_vec[i][f] = ch_vector[(i*FEATURES + f)*IN_WIDTH +: IN_WIDTH];
                    end else begin
                        m_drops++;
                    end
                end
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle against the model and the expectation queues.
    logic [CHANNEL_COUNT-1:0] exp_rdy;
    bit                       issuing;
    res_t                     r;
    always @(negedge clk) begin
        issuing = (m_in_flight >= 0) && (m_to_send > 0);
        for (int i = 0; i < CHANNEL_COUNT; i++) exp_rdy[i] = !m_full[i];
        check("ch_ready", ch_ready, exp_rdy);
        check("core_in_valid", core_in_valid, issuing && core_ready);
        if (m_in_flight >= 0) check("core_ch_index", core_ch_index, m_in_flight);
        if (issuing) begin
            check("feat_queue_nonempty", exp_feat.size() > 0, 1);
            if (exp_feat.size() > 0) begin
                check("core_sample", core_sample, exp_feat[0].val);
                if (core_in_valid && core_ready) void'(exp_feat.pop_front());
            end
        end
        if (exp_res.size() > 0) begin
            r = exp_res.pop_front();
            check("res_valid", res_valid, 1);
            if (res_valid) begin
                check("res_channel", res_channel, r.ch);
                check("res_level", res_level, r.level);
                check("res_path", res_path, r.path);
            end
        end else begin
            check("res_valid_idle", res_valid, 0);
        end
`ifdef DTREE_SCHED_DROP_CNT_EN
        check("drop_count", drop_count, (m_drops > 65535) ? 65535 : m_drops);
`endif
    end

    // Core stand-in: drives core_ready and result strobes from the control knobs.
    initial begin
        core_ready     = 1'b1;
        core_out_valid = 1'b0;
        core_level     = '0;
        core_path      = '0;
        forever begin
            step();
            core_out_valid = 1'b0;
            if (stall_left > 0 && m_in_flight >= 0 && m_to_send == FEATURES - 1) begin
                core_ready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                core_ready = ($urandom_range(0, 3) != 0);
            end else begin
                core_ready = 1'b1;
            end
            if (pulse_done != pulse_cnt) begin
                pulse_done     = pulse_cnt;
                core_out_valid = 1'b1;
                core_level     = LP_W'(pulse_lvl);
                core_path      = LP_W'(pulse_pth);
            end else if (auto_core && m_in_flight >= 0 && m_to_send == 0) begin
                if (resp_wait == 0) begin
                    core_out_valid = 1'b1;
                    core_level     = LP_W'($urandom_range(0, 3));
                    core_path      = LP_W'($urandom_range(0, 3));
                    resp_wait      = $urandom_range(0, 3);
                end else begin
                    resp_wait--;
                end
            end else if (spurious_en && $urandom_range(0, 15) == 0) begin
                core_out_valid = 1'b1;
                core_level     = LP_W'($urandom_range(0, 3));
                core_path      = LP_W'($urandom_range(0, 3));
            end
        end
    end

    task automatic offer(input int ch, input int f0, input int f1, input int f2);
        ch_vector[(ch*FEATURES + 0)*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(f0);
        ch_vector[(ch*FEATURES + 1)*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(f1);
        ch_vector[(ch*FEATURES + 2)*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(f2);
        ch_valid[ch] = 1'b1;
        step();
        ch_valid[ch] = 1'b0;
    endtask

    task automatic pulse(input int lvl, input int pth);
        pulse_lvl = lvl;
        pulse_pth = pth;
        pulse_cnt++;
    endtask

    function automatic bit model_idle();
        bit idle = (m_in_flight < 0) && (exp_feat.size() == 0) && (exp_res.size() == 0);
        for (int i = 0; i < CHANNEL_COUNT; i++) if (m_full[i]) idle = 1'b0;
        return idle;
    endfunction

    task automatic wait_in_wait(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = (m_in_flight >= 0) && (m_to_send == 0);
        end
        check(name, ok, 1);
        step();
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = model_idle();
        end
        check(name, ok, 1);
        step();
    endtask

    initial begin
        reset     = 1'b1;
        ch_valid  = '0;
        ch_vector = '0;
        repeat (3) step();
        @(negedge clk);
        check("rst_ch_ready", ch_ready, 4'hF);
        check("rst_core_in_valid", core_in_valid, 0);
        check("rst_core_sample", core_sample, 0);
        check("rst_core_ch_index", core_ch_index, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_channel", res_channel, 0);
        check("rst_res_level", res_level, 0);
        check("rst_res_path", res_path, 0);
        step();
        reset = 1'b0;
        step();

        // Single vector on channel 1, result level 1 / path 2
        auto_core = 1'b0;
        offer(1, 30, -5, 7);
        wait_in_wait("t1_reach_wait");
        pulse(1, 2);
        wait_idle("t1_idle", 50);

        // Spurious result strobe while idle must be ignored
        pulse(3, 3);
        repeat (4) step();
        check("spurious_idle_grant", core_in_valid, 0);
        auto_core = 1'b1;

        // All channels at once, then channel 0 re-offers after its grant
        for (int i = 0; i < CHANNEL_COUNT; i++)
            for (int f = 0; f < FEATURES; f++)
                ch_vector[(i*FEATURES + f)*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(100*i + f);
        ch_valid = '1;
        step();
        ch_valid = '0;
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                ok = !m_full[0];
            end
            check("t2_ch0_granted", ok, 1);
            step();
        end
        offer(0, 11, 22, 33);
        wait_idle("t2_idle", 200);

        // core_ready stalls after feature 0 for 5 cycles
        stall_left = 5;
        offer(2, -100, 200, -300);
        wait_idle("t3_idle", 100);
        check("t3_stall_used", stall_left, 0);

        // Offer to a full channel is dropped; buffered vector survives
        auto_core = 1'b0;
        offer(0, 1, 2, 3);
        offer(2, 44, 55, 66);
        step();
        offer(2, 77, 88, 99);
        check("t4_drop_seen", m_drops, 1);
        auto_core = 1'b1;
        wait_idle("t4_idle", 200);

        // Reset while waiting for a result, with channel 3 buffered
        auto_core = 1'b0;
        offer(0, 5, 6, 7);
        wait_in_wait("t5_reach_wait");
        offer(3, 8, 9, 10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t5_ch_ready", ch_ready, 4'hF);
        check("t5_core_in_valid", core_in_valid, 0);
        step();
        pulse(2, 1);
        repeat (4) step();
        auto_core = 1'b1;

`ifdef DTREE_SCHED_DROP_CNT_EN
        // Flood full channels so the drop counter saturates
        auto_core = 1'b0;
        ch_valid  = '1;
        repeat (24000) step();
        ch_valid = '0;
        @(negedge clk);
        check("sat_drop_count", drop_count, 16'hFFFF);
        step();
        reset = 1'b1;
        step();
        reset     = 1'b0;
        auto_core = 1'b1;
        step();
`endif

        // Randomized traffic with random core_ready and spurious strobes
        rand_ready  = 1'b1;
        spurious_en = 1'b1;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                ch_valid[i] = ($urandom_range(0, 5) == 0);
                for (int f = 0; f < FEATURES; f++)
                    ch_vector[(i*FEATURES + f)*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'($urandom);
            end
            step();
        end
        ch_valid    = '0;
        rand_ready  = 1'b0;
        spurious_en = 1'b0;
        wait_idle("drain_idle", 2000);
        check("drain_queues", exp_feat.size() + exp_res.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
